// File: rtl/rmt_pkg.sv
// Shared RMT stage definitions: default datapath widths, the PHV/action sync
// output-state encoding and a small parameter-check helper.
package rmt_pkg;

  localparam int PHV_LEN_DEF    = 2304;
  localparam int ACT_LEN_DEF    = 64;
  localparam int C_NUM_PHVS_DEF = 65;

  typedef enum logic {
    OUT_IDLE  = 1'b0,
    OUT_ISSUE = 1'b1
  } out_state_e;

  function automatic bit is_pow2_min2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/rmt_sync_fifo.sv
// Single-clock FIFO with occupancy count and a combinational head.
// Writes are refused when full and reads are refused when empty.
module rmt_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_wr_en,
  input  logic [WIDTH-1:0]        i_wr_data,
  input  logic                    i_rd_en,
  output logic [WIDTH-1:0]        o_rd_data,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign w_do_rd   = i_rd_en && (r_count != '0);
  assign w_do_wr   = i_wr_en && (r_count < CW'(DEPTH));
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage needs no reset: emptying the pointers/count discards contents.
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/phv_action_sync.sv
// Pairs each accepted PHV with its in-order action word and issues the pair to the crossbar.
// Define PHV_SYNC_STATS_EN to add the stat_pairs / stat_stall counters.
module phv_action_sync
  import rmt_pkg::*;
#(
  parameter int STAGE_ID   = 0,
  parameter int PHV_LEN    = PHV_LEN_DEF,
  parameter int ACT_LEN    = ACT_LEN_DEF,
  parameter int C_NUM_PHVS = C_NUM_PHVS_DEF,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PHV_LEN-1:0]            phv_in,
  input  logic                          phv_in_valid,
  output logic                          phv_ready_out,
  input  logic [ACT_LEN*C_NUM_PHVS-1:0] action_in,
  input  logic                          action_in_valid,
  output logic [PHV_LEN-1:0]            phv_out,
  output logic [ACT_LEN*C_NUM_PHVS-1:0] action_out,
  output logic                          out_valid,
  input  logic                          ready_in,
  output logic                          err_sticky
`ifdef PHV_SYNC_STATS_EN
  ,
  output logic [31:0]                   stat_pairs,
  output logic [31:0]                   stat_stall
`endif
);

  localparam int AWID = ACT_LEN * C_NUM_PHVS;
  localparam int CW   = $clog2(DEPTH) + 1;

  if (!is_pow2_min2(DEPTH)) begin : g_depth_check
    $error("phv_action_sync stage %0d: DEPTH=%0d must be a power of two >= 2", STAGE_ID, DEPTH);
  end

  logic [CW-1:0]      w_phv_count;
  logic [CW-1:0]      w_act_count;
  logic [PHV_LEN-1:0] w_phv_head;
  logic [AWID-1:0]    w_act_head;
  logic [CW-1:0]      w_outstanding;
  logic               w_phv_acc;
  logic               w_act_acc;
  logic               w_act_drop;
  logic               w_pop;
  logic               w_out_valid;

  out_state_e         r_state;
  out_state_e         w_next_state;
  logic [PHV_LEN-1:0] r_phv_out;
  logic [AWID-1:0]    r_act_out;
  logic               r_err;

  assign phv_ready_out = (w_phv_count < CW'(DEPTH));
  assign w_phv_acc     = phv_in_valid && phv_ready_out;

  // A PHV arriving on the same edge already counts as outstanding for its action.
  assign w_outstanding = w_phv_count + CW'(w_phv_acc) - w_act_count;
  assign w_act_acc     = action_in_valid && (w_outstanding != '0);
  assign w_act_drop    = action_in_valid && (w_outstanding == '0);

  assign w_pop = (w_phv_count != '0) && (w_act_count != '0) && ready_in;

  rmt_sync_fifo #(
    .WIDTH (PHV_LEN),
    .DEPTH (DEPTH)
  ) u_phv_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_phv_acc),
    .i_wr_data (phv_in),
    .i_rd_en   (w_pop),
    .o_rd_data (w_phv_head),
    .o_count   (w_phv_count)
  );

  rmt_sync_fifo #(
    .WIDTH (AWID),
    .DEPTH (DEPTH)
  ) u_act_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_act_acc),
    .i_wr_data (action_in),
    .i_rd_en   (w_pop),
    .o_rd_data (w_act_head),
    .o_count   (w_act_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OUT_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = OUT_IDLE;
    w_out_valid  = 1'b0;
    case (r_state)
      OUT_IDLE: begin
        if (w_pop) begin
          w_next_state = OUT_ISSUE;
        end
      end
      OUT_ISSUE: begin
        w_out_valid = 1'b1;
        if (w_pop) begin
          w_next_state = OUT_ISSUE;
        end
      end
      default: w_next_state = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phv_out <= '0;
      r_act_out <= '0;
    end else if (w_pop) begin
      r_phv_out <= w_phv_head;
      r_act_out <= w_act_head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_act_drop) begin
      r_err <= 1'b1;
    end
  end

  assign phv_out    = r_phv_out;
  assign action_out = r_act_out;
  assign out_valid  = w_out_valid;
  assign err_sticky = r_err;

`ifdef PHV_SYNC_STATS_EN
  logic [31:0] r_stat_pairs;
  logic [31:0] r_stat_stall;

  // Pairs are counted on the launching edge so the count moves with out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_pairs <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_pop) begin
        r_stat_pairs <= r_stat_pairs + 32'd1;
      end
      if ((w_phv_count != '0) && (w_act_count != '0) && !ready_in) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end

  assign stat_pairs = r_stat_pairs;
  assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_phv_action_sync.sv
// Self-checking bench for phv_action_sync: directed scenarios then random traffic
// against a queue-based pairing model. Checks stat ports when PHV_SYNC_STATS_EN is defined.
`timescale 1ns/1ps
module tb_phv_action_sync;

  localparam int PW    = rmt_pkg::PHV_LEN_DEF;
  localparam int AL    = rmt_pkg::ACT_LEN_DEF;
  localparam int CN    = rmt_pkg::C_NUM_PHVS_DEF;
  localparam int AW    = AL * CN;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] phv_in;
  logic          phv_in_valid;
  logic          phv_ready_out;
  logic [AW-1:0] action_in;
  logic          action_in_valid;
  logic [PW-1:0] phv_out;
  logic [AW-1:0] action_out;
  logic          out_valid;
  logic          ready_in;
  logic          err_sticky;
`ifdef PHV_SYNC_STATS_EN
  logic [31:0]   stat_pairs;
  logic [31:0]   stat_stall;
`endif

  always #5 clk = ~clk;

  phv_action_sync #(
    .STAGE_ID   (0),
    .PHV_LEN    (PW),
    .ACT_LEN    (AL),
    .C_NUM_PHVS (CN),
    .DEPTH      (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .phv_in          (phv_in),
    .phv_in_valid    (phv_in_valid),
    .phv_ready_out   (phv_ready_out),
    .action_in       (action_in),
    .action_in_valid (action_in_valid),
    .phv_out         (phv_out),
    .action_out      (action_out),
    .out_valid       (out_valid),
    .ready_in        (ready_in),
    .err_sticky      (err_sticky)
`ifdef PHV_SYNC_STATS_EN
    ,
    .stat_pairs      (stat_pairs),
    .stat_stall      (stat_stall)
`endif
  );

  // Reference model: two in-order queues and the expected output registers.
  logic [PW-1:0] phvQ [$];
  logic [AW-1:0] actQ [$];
  logic [PW-1:0] expPhvOut;
  logic [AW-1:0] expActOut;
  logic          expValid;
  logic          expErr;
  int unsigned   expPairs;
  int unsigned   expStall;

  int checkCount = 0;
  int failCount  = 0;

  function automatic logic [PW-1:0] randPhv();
    logic [PW-1:0] v;
    for (int i = 0; i < PW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] randAct();
    logic [AW-1:0] v;
    for (int i = 0; i < AW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic checkBit(input string tag, input logic got, input logic exp);
    checkCount++;
    assert (got === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic checkWide(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    checkCount++;
    assert (got === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed[63:0]=%h expected[63:0]=%h observed[top32]=%h expected[top32]=%h",
             tag, got[63:0], exp[63:0], got[AW-1 -: 32], exp[AW-1 -: 32]);
    end
  endtask

  task automatic checkWord(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    assert (got === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    phvQ.delete();
    actQ.delete();
    expPhvOut = '0;
    expActOut = '0;
    expValid  = 1'b0;
    expErr    = 1'b0;
    expPairs  = 0;
    expStall  = 0;
  endtask

  // One clock edge of the pairing rules, applied to the model queues.
  task automatic modelEdge(input logic pv, input logic [PW-1:0] pd, input logic av,
                           input logic [AW-1:0] ad, input logic rdy);
    bit pop;
    bit phvAcc;
    int outstanding;
    pop         = (phvQ.size() > 0) && (actQ.size() > 0) && rdy;
    phvAcc      = pv && (phvQ.size() < DEPTH);
    outstanding = phvQ.size() + (phvAcc ? 1 : 0) - actQ.size();
    if (!rdy && phvQ.size() > 0 && actQ.size() > 0) expStall++;
    if (pop) begin
      expPhvOut = phvQ.pop_front();
      expActOut = actQ.pop_front();
      expPairs++;
    end
    expValid = pop;
    if (phvAcc) phvQ.push_back(pd);
    if (av) begin
      if (outstanding > 0) actQ.push_back(ad);
      else expErr = 1'b1;
    end
  endtask

  task automatic checkOutput();
    checkBit("out_valid", out_valid, expValid);
    checkBit("phv_ready_out", phv_ready_out, (phvQ.size() < DEPTH));
    checkBit("err_sticky", err_sticky, expErr);
    checkWide("phv_out", AW'(phv_out), AW'(expPhvOut));
    checkWide("action_out", action_out, expActOut);
`ifdef PHV_SYNC_STATS_EN
    checkWord("stat_pairs", stat_pairs, expPairs);
    checkWord("stat_stall", stat_stall, expStall);
`endif
  endtask

  task automatic applyStimulus(input logic pv, input logic [PW-1:0] pd, input logic av,
                               input logic [AW-1:0] ad, input logic rdy);
    @(negedge clk);
    phv_in_valid    = pv;
    phv_in          = pd;
    action_in_valid = av;
    action_in       = ad;
    ready_in        = rdy;
    @(posedge clk);
    modelEdge(pv, pd, av, ad, rdy);
    #1;
    checkOutput();
  endtask

  task automatic idleStep(input logic rdy);
    applyStimulus(1'b0, '0, 1'b0, '0, rdy);
  endtask

  initial begin
    logic [PW-1:0] phvA5;
    logic [AW-1:0] act5A;
    int pulses;
    logic [31:0] stallBase;

    rst_n           = 1'b0;
    phv_in          = '0;
    phv_in_valid    = 1'b0;
    action_in       = '0;
    action_in_valid = 1'b0;
    ready_in        = 1'b0;
    modelReset();
    stallBase = 0;

    #3;
    checkBit("reset_out_valid", out_valid, 1'b0);
    checkBit("reset_ready", phv_ready_out, 1'b1);
    checkBit("reset_err", err_sticky, 1'b0);
    checkWide("reset_phv_out", AW'(phv_out), '0);
    checkWide("reset_action_out", action_out, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Same-edge PHV and action: pair appears two edges later.
    phvA5 = {(PW/8){8'hA5}};
    act5A = {(AW/8){8'h5A}};
    applyStimulus(1'b1, phvA5, 1'b1, act5A, 1'b1);
    checkBit("pair_not_yet", out_valid, 1'b0);
    idleStep(1'b1);
    checkBit("pair_valid", out_valid, 1'b1);
    checkWide("pair_phv", AW'(phv_out), AW'(phvA5));
    checkWide("pair_act", action_out, act5A);
    idleStep(1'b1);
    checkBit("pair_single_pulse", out_valid, 1'b0);

    // Fill the PHV FIFO, try a fifth, then release with four actions.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, randPhv(), 1'b0, '0, 1'b1);
    checkBit("full_after_4", phv_ready_out, 1'b0);
    applyStimulus(1'b1, randPhv(), 1'b0, '0, 1'b1);
    pulses = 0;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, '0, 1'b1, randAct(), 1'b1);
      if (out_valid === 1'b1) pulses++;
    end
    for (int i = 0; i < 3; i++) begin
      idleStep(1'b1);
      if (out_valid === 1'b1) pulses++;
    end
    checkWord("burst_pulses", pulses, 4);

    // Late action: PHV on step 0, action on step 10, pair visible after step 11.
    for (int k = 0; k < 13; k++) begin
      applyStimulus(k == 0, randPhv(), k == 10, randAct(), 1'b1);
      if (k == 11) checkBit("late_valid", out_valid, 1'b1);
      else if (k < 11) checkBit("late_early", out_valid, 1'b0);
    end

    // Two pairs held off by ready_in=0, then drained back to back.
`ifdef PHV_SYNC_STATS_EN
    stallBase = stat_stall;
`endif
    applyStimulus(1'b1, randPhv(), 1'b1, randAct(), 1'b0);
    applyStimulus(1'b1, randPhv(), 1'b1, randAct(), 1'b0);
    for (int i = 0; i < 4; i++) begin
      idleStep(1'b0);
      checkBit("stall_no_valid", out_valid, 1'b0);
    end
`ifdef PHV_SYNC_STATS_EN
    checkWord("stall_count", stat_stall - stallBase, 32'd5);
`endif
    idleStep(1'b1);
    checkBit("drain_first", out_valid, 1'b1);
    idleStep(1'b1);
    checkBit("drain_second", out_valid, 1'b1);
    idleStep(1'b1);
    checkBit("drain_done", out_valid, 1'b0);

    // Action with nothing outstanding is dropped and flags an error.
    checkBit("err_clear_before", err_sticky, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, randAct(), 1'b1);
    checkBit("err_set", err_sticky, 1'b1);
    applyStimulus(1'b1, randPhv(), 1'b0, '0, 1'b1);
    idleStep(1'b1);
    checkBit("err_no_pair", out_valid, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, randAct(), 1'b1);
    idleStep(1'b1);
    checkBit("pair_after_drop", out_valid, 1'b1);

    // Mid-operation asynchronous reset with three PHVs queued.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, randPhv(), 1'b0, '0, 1'b1);
    @(negedge clk);
    phv_in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkBit("async_out_valid", out_valid, 1'b0);
    checkBit("async_err", err_sticky, 1'b0);
    checkWide("async_phv_out", AW'(phv_out), '0);
    checkWide("async_action_out", action_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkBit("ready_after_release", phv_ready_out, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, randAct(), 1'b1);
    checkBit("flushed_err", err_sticky, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) < 50, randPhv(),
                    $urandom_range(0, 99) < 40, randAct(),
                    $urandom_range(0, 99) < 65);
    end
    for (int i = 0; i < 8; i++) idleStep(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/phv_action_sync.md
PHV_ACTION_SYNC -- requirements
Module: phv_action_sync

Interface
REQ-001 Parameter STAGE_ID, 0, pipeline stage index (informational).
REQ-002 Parameter PHV_LEN, 2304, PHV width (64x32-bit containers + 256-bit metadata).
REQ-003 Parameter ACT_LEN, 64, width of one per-container action.
REQ-004 Parameter C_NUM_PHVS, 65, actions per action word.
REQ-005 Parameter DEPTH, 4, entries per internal FIFO (power of 2, >=2).
REQ-006 Ports:
  clk  in  1  clock; single clock domain
  rst_n  in  1  asynchronous active-low reset
  phv_in  in  PHV_LEN  PHV from parser/previous stage
  phv_in_valid  in  1  PHV strobe
  phv_ready_out  out  1  space available for a PHV
  action_in  in  ACT_LEN*C_NUM_PHVS  action word from lookup engine
  action_in_valid  in  1  action strobe; no backpressure
  phv_out  out  PHV_LEN  PHV to crossbar
  action_out  out  ACT_LEN*C_NUM_PHVS  action paired with phv_out
  out_valid  out  1  one-cycle pulse, pair valid
  ready_in  in  1  crossbar ready
  err_sticky  out  1  protocol error seen

Function
REQ-007 PHV accepted at a clk edge iff phv_in_valid && phv_ready_out; written to PHV FIFO.
REQ-008 phv_ready_out SHALL be 1 iff PHV FIFO count < DEPTH; no full-bypass (full blocks even if a pop occurs the same cycle).
REQ-009 Action accepted whenever action_in_valid=1 and outstanding (PHV count - action count) > 0; written to action FIFO.
REQ-010 Action strobe with outstanding = 0 SHALL be dropped and set err_sticky.
REQ-011 Pairing strictly in order: Nth action pairs with Nth accepted PHV.
REQ-012 Pop both FIFO heads into registered phv_out/action_out when both non-empty and ready_in=1; out_valid=1 for exactly that following cycle, else 0.
REQ-013 No issue when ready_in=0; heads held, out_valid=0, phv_out/action_out hold last value.
REQ-014 Minimum latency: PHV and action sampled at edge E -> out_valid high in cycle after edge E+1 (2 edges).
REQ-015 Back-to-back pairs issued every cycle while ready_in=1 and data available.
REQ-016 Simultaneous write and pop on one FIFO in one cycle SHALL be supported; count unchanged.
REQ-017 Pointers wrap modulo DEPTH; counts are log2(DEPTH)+1 bits.
REQ-018 Output state machine: IDLE (out_valid=0) -> ISSUE on pop; ISSUE -> ISSUE on further pop, else IDLE.

Reset
REQ-019 rst_n low asynchronously clears FIFOs, pointers, counts, err_sticky, out_valid=0, phv_out=0, action_out=0, state=IDLE.
REQ-020 phv_ready_out=1 after reset; in-flight PHVs/actions discarded on mid-operation reset.

Configuration
REQ-021 Macro PHV_SYNC_STATS_EN defined: adds outputs stat_pairs[31:0] (increments per out_valid) and stat_stall[31:0] (increments per cycle both heads non-empty and ready_in=0), both reset to 0, wrapping at 2^32.
REQ-022 Macro undefined: stat ports and counters absent; all other behaviour identical.

Structure
REQ-023 Shared package rmt_pkg holds PHV_LEN, ACT_LEN, C_NUM_PHVS defaults and the output-state enum.
REQ-024 One sub-module rmt_sync_fifo (parameters WIDTH, DEPTH; async active-low reset; count output), instantiated twice.

Verification
REQ-025 PHV 0xA5.. and action with same-edge strobes, ready_in=1 -> out_valid pulse 2 edges later with both values intact.
REQ-026 4 PHVs, no actions -> phv_ready_out=0 after 4th; 5th phv_in_valid ignored; then 4 actions -> 4 consecutive pairs in order.
REQ-027 PHV at cycle 0, action at cycle 10 -> out_valid in cycle 12, none earlier.
REQ-028 ready_in=0 for 5 cycles with 2 pairs pending -> no out_valid; ready_in=1 -> 2 pulses in consecutive cycles (stat_stall=5 if PHV_SYNC_STATS_EN).
REQ-029 action_in_valid with no PHV outstanding -> err_sticky=1, FIFOs unchanged.
REQ-030 rst_n low with 3 entries queued -> all outputs zero immediately, phv_ready_out=1 after release.
